midi_voice_ctrl: RTL and testbench

Polyphonic note controller that sits downstream of the MIDI UART receiver. It consumes the receiver's byte stream and parses Note-On/Note-Off messages for one MIDI channel, including running status. It allocates each sounding note to one of `NUM_VOICES` voice slots and drives per-voice note/velocity/active registers, which feed tone generators and the LED display.

---
 rtl/midi_pkg.sv | 16 +
 rtl/midi_voice_alloc.sv | 35 +++
 rtl/midi_voice_ctrl.sv | 150 +++++++++++++++
 tb/tb_midi_voice_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared constants for the MIDI note controller.
// Status nibbles, real-time threshold, parser states, default voice count.
package midi_pkg;

    localparam logic [3:0] NOTE_ON   = 4'h9;
    localparam logic [3:0] NOTE_OFF  = 4'h8;
    localparam logic [7:0] RT_THRESH = 8'hF8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_D1 = 2'd1;
    localparam logic [1:0] ST_WAIT_D2 = 2'd2;
    localparam logic [1:0] ST_EXEC    = 2'd3;

    localparam int DEF_NUM_VOICES = 4;

endpackage

// File: rtl/midi_voice_alloc.sv
// Combinational voice lookup: active voice holding a note, lowest free voice.
// In: note, voice_active, voice_note. Out: match_hit/idx, free_hit/idx.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES
) (
    input  logic [6:0]              note,
    input  logic [NUM_VOICES-1:0]   voice_active,
    input  logic [7*NUM_VOICES-1:0] voice_note,
    output logic                    match_hit,
    output logic [2:0]              match_idx,
    output logic                    free_hit,
    output logic [2:0]              free_idx
);

    // Scan downward so the lowest index is the last one written.
    always_comb begin
        match_hit = 1'b0;
        match_idx = 3'd0;
        free_hit  = 1'b0;
        free_idx  = 3'd0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_active[i] && voice_note[7*i +: 7] == note) begin
                match_hit = 1'b1;
                match_idx = 3'(i);
            end
            if (!voice_active[i]) begin
                free_hit = 1'b1;
                free_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/midi_voice_ctrl.sv
// MIDI Note-On/Off parser with running status and polyphonic voice allocation.
// In: clk, rst_n, byte_in/byte_valid. Out: voice regs, evt pulse, overrun.
module midi_voice_ctrl
    import midi_pkg::*;
#(
    parameter int         NUM_VOICES = DEF_NUM_VOICES,
    parameter logic [3:0] CHANNEL    = 4'h0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_vel,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic                    evt_valid,
    output logic [2:0]              evt_voice,
    output logic                    overrun
);

    logic [1:0] state_q, state_d;
    logic       kind_on_q, kind_on_d;
    logic [6:0] note_q, note_d;
    logic [6:0] vel_q, vel_d;
    logic [2:0] steal_q, steal_d;
    logic [NUM_VOICES-1:0][6:0] vnote_q, vnote_d;
    logic [NUM_VOICES-1:0][6:0] vvel_q, vvel_d;
    logic [NUM_VOICES-1:0] act_q, act_d;
    logic       evt_valid_q, evt_valid_d;
    logic [2:0] evt_voice_q, evt_voice_d;
    logic       overrun_q, overrun_d;

    logic       match_hit, free_hit;
    logic [2:0] match_idx, free_idx;

    midi_voice_alloc #(.NUM_VOICES(NUM_VOICES)) u_alloc (
        .note         (note_q),
        .voice_active (act_q),
        .voice_note   (vnote_q),
        .match_hit    (match_hit),
        .match_idx    (match_idx),
        .free_hit     (free_hit),
        .free_idx     (free_idx)
    );

    logic       is_rt, our_msg, key_on;
    logic [2:0] tgt;

    assign is_rt   = byte_in >= RT_THRESH;
    assign our_msg = (byte_in[7:4] == NOTE_ON || byte_in[7:4] == NOTE_OFF)
                     && byte_in[3:0] == CHANNEL;
    // Note-On with velocity 0 is a release.
    assign key_on  = kind_on_q && vel_q != 7'd0;

    always_comb begin
        state_d     = state_q;
        kind_on_d   = kind_on_q;
        note_d      = note_q;
        vel_d       = vel_q;
        steal_d     = steal_q;
        vnote_d     = vnote_q;
        vvel_d      = vvel_q;
        act_d       = act_q;
        evt_valid_d = 1'b0;
        evt_voice_d = evt_voice_q;
        overrun_d   = overrun_q;
        tgt         = 3'd0;

        if (state_q == ST_EXEC) begin
            if (byte_valid) overrun_d = 1'b1;
            state_d = ST_WAIT_D1;
            if (key_on) begin
                if (match_hit) begin
                    tgt = match_idx;
                end else if (free_hit) begin
                    tgt = free_idx;
                end else begin
                    tgt     = steal_q;
                    steal_d = (steal_q == 3'(NUM_VOICES - 1))
                              ? 3'd0 : steal_q + 3'd1;
                end
                evt_valid_d = 1'b1;
                evt_voice_d = tgt;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (3'(i) == tgt) begin
                        vnote_d[i] = note_q;
                        vvel_d[i]  = vel_q;
                        act_d[i]   = 1'b1;
                    end
                end
            end else if (match_hit) begin
                evt_valid_d = 1'b1;
                evt_voice_d = match_idx;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (3'(i) == match_idx) act_d[i] = 1'b0;
                end
            end
        end else if (byte_valid && !is_rt) begin
            if (our_msg) begin
                kind_on_d = byte_in[4];
                state_d   = ST_WAIT_D1;
            end else if (byte_in[7]) begin
                kind_on_d = 1'b0;
                state_d   = ST_IDLE;
            end else if (state_q == ST_WAIT_D1) begin
                note_d  = byte_in[6:0];
                state_d = ST_WAIT_D2;
            end else if (state_q == ST_WAIT_D2) begin
                vel_d   = byte_in[6:0];
                state_d = ST_EXEC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kind_on_q   <= 1'b0;
            note_q      <= 7'd0;
            vel_q       <= 7'd0;
            steal_q     <= 3'd0;
            vnote_q     <= '0;
            vvel_q      <= '0;
            act_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_voice_q <= 3'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_on_q   <= kind_on_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            steal_q     <= steal_d;
            vnote_q     <= vnote_d;
            vvel_q      <= vvel_d;
            act_q       <= act_d;
            evt_valid_q <= evt_valid_d;
            evt_voice_q <= evt_voice_d;
            overrun_q   <= overrun_d;
        end
    end

    assign voice_note   = vnote_q;
    assign voice_vel    = vvel_q;
    assign voice_active = act_q;
    assign evt_valid    = evt_valid_q;
    assign evt_voice    = evt_voice_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_midi_voice_ctrl.sv
// Scoreboard bench for midi_voice_ctrl: directed scenarios plus random bytes.
// Reference model tracks messages and voices; monitor checks each event.
module tb_midi_voice_ctrl;

    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      byte_in = 8'h00;
    logic            byte_valid = 1'b0;
    logic [7*NV-1:0] voice_note;
    logic [7*NV-1:0] voice_vel;
    logic [NV-1:0]   voice_active;
    logic            evt_valid;
    logic [2:0]      evt_voice;
    logic            overrun;

    always #5 clk = ~clk;

    midi_voice_ctrl #(.NUM_VOICES(NV), .CHANNEL(4'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .voice_note   (voice_note),
        .voice_vel    (voice_vel),
        .voice_active (voice_active),
        .evt_valid    (evt_valid),
        .evt_voice    (evt_voice),
        .overrun      (overrun)
    );

    typedef struct {
        int voice;
        int note;
        int vel;
        int act;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int   m_note[NV];
    int   m_vel[NV];
    int   m_act[NV];
    int   m_steal;
    bit   m_have;
    bit   m_on;
    int   pend[$];

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 0;
            m_vel[i]  = 0;
            m_act[i]  = 0;
        end
        m_steal = 0;
        m_have  = 0;
        m_on    = 0;
        pend.delete();
    endfunction

    function automatic void model_apply(int n, int v);
        int idx = -1;
        for (int i = 0; i < NV; i++)
            if (idx < 0 && m_act[i] != 0 && m_note[i] == n) idx = i;
        if (m_on && v != 0) begin
            for (int i = 0; i < NV; i++)
                if (idx < 0 && m_act[i] == 0) idx = i;
            if (idx < 0) begin
                idx = m_steal;
                m_steal = (m_steal + 1) % NV;
            end
            m_note[idx] = n;
            m_vel[idx]  = v;
            m_act[idx]  = 1;
        end else begin
            if (idx < 0) return;
            m_act[idx] = 0;
        end
        sb.push_back('{idx, m_note[idx], m_vel[idx], m_act[idx]});
    endfunction

    function automatic void model_byte(logic [7:0] b);
        if (b >= 8'hF8) return;
        if (b[7]) begin
            pend.delete();
            m_have = (b[7:4] == 4'h9 || b[7:4] == 4'h8) && b[3:0] == 4'h0;
            m_on   = m_have && b[4];
            return;
        end
        if (!m_have) return;
        pend.push_back(int'(b));
        if (pend.size() == 2) begin
            model_apply(pend[0], pend[1]);
            pend.delete();
        end
    endfunction

    task automatic send(logic [7:0] b, int gap);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        model_byte(b);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send3(logic [7:0] a, logic [7:0] b, logic [7:0] c);
        send(a, 2);
        send(b, 2);
        send(c, 2);
    endtask

    task automatic drain(string name);
        repeat (6) @(negedge clk);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_state();
        for (int i = 0; i < NV; i++) begin
            check("state_active", int'(voice_active[i]), m_act[i]);
            check("state_note", int'(voice_note[7*i +: 7]), m_note[i]);
            check("state_vel", int'(voice_vel[7*i +: 7]), m_vel[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    exp_t e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && evt_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL evt_unexpected: voice %0d pulsed, none expected",
                             evt_voice);
                end else begin
                    e = sb.pop_front();
                    check("evt_voice", int'(evt_voice), e.voice);
                    check("evt_note", int'(voice_note[7*e.voice +: 7]), e.note);
                    check("evt_vel", int'(voice_vel[7*e.voice +: 7]), e.vel);
                    check("evt_active", int'(voice_active[e.voice]), e.act);
                end
            end
        end
    end

    initial begin
        int r;
        logic [7:0] b;

        model_reset();
        repeat (2) @(negedge clk);
        check("rst_note", int'(voice_note), 0);
        check("rst_vel", int'(voice_vel), 0);
        check("rst_active", int'(voice_active), 0);
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_voice", int'(evt_voice), 0);
        check("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        // basic on/off with latency
        send(8'h90, 2);
        send(8'h3C, 2);
        send(8'h40, 0);
        check("lat_k", int'(evt_valid), 0);
        @(negedge clk);
        check("lat_k1", int'(evt_valid), 1);
        @(negedge clk);
        check("lat_k2", int'(evt_valid), 0);
        drain("basic_on_drain");
        check("basic_note", int'(voice_note[6:0]), 'h3C);
        check("basic_vel", int'(voice_vel[6:0]), 'h40);
        send3(8'h80, 8'h3C, 8'h00);
        drain("basic_off_drain");
        check("basic_off", int'(voice_active[0]), 0);
        check("basic_held", int'(voice_note[6:0]), 'h3C);

        // running status
        do_reset();
        send3(8'h90, 8'h3C, 8'h40);
        send(8'h40, 2);
        send(8'h40, 2);
        send(8'h3C, 2);
        send(8'h00, 2);
        drain("rs_drain");
        check("rs_v1_note", int'(voice_note[13:7]), 'h40);
        check("rs_active", int'(voice_active), 'b0010);
        check_state();

        // stealing
        do_reset();
        for (int n = 60; n <= 65; n++) send3(8'h90, 8'(n), 8'h40);
        drain("steal_drain");
        check("steal_v0", int'(voice_note[6:0]), 64);
        check("steal_v1", int'(voice_note[13:7]), 65);
        check_state();

        // filtering
        do_reset();
        send3(8'h91, 8'h3C, 8'h40);
        send(8'h90, 2);
        send(8'h3C, 2);
        send(8'hF8, 2);
        send(8'h40, 2);
        send(8'h90, 2);
        send(8'h3C, 2);
        send(8'hB0, 2);
        send(8'h40, 2);
        send(8'h3C, 2);
        send(8'h40, 2);
        drain("filter_drain");
        check("filter_active", int'(voice_active), 1);
        check("filter_note", int'(voice_note[6:0]), 'h3C);

        // retrigger and unmatched off
        do_reset();
        send3(8'h90, 8'h3C, 8'h40);
        send3(8'h90, 8'h3C, 8'h7F);
        send3(8'h80, 8'h50, 8'h00);
        drain("retrig_drain");
        check("retrig_active", int'(voice_active), 1);
        check("retrig_vel", int'(voice_vel[6:0]), 'h7F);

        // random traffic
        do_reset();
        for (int k = 0; k < 700; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10)      b = 8'h90;
            else if (r < 16) b = 8'h80;
            else if (r < 19) b = 8'(8'h80 | $urandom_range(1, 31));
            else if (r < 22) b = 8'(8'hA0 + $urandom_range(0, 79));
            else if (r < 24) b = 8'(8'hF0 + $urandom_range(0, 7));
            else if (r < 28) b = 8'(8'hF8 + $urandom_range(0, 7));
            else if (r < 36) b = 8'h00;
            else             b = 8'(56 + $urandom_range(0, 11));
            send(b, int'($urandom_range(0, 2)));
        end
        drain("rand_drain");
        check_state();
        check("rand_overrun", int'(overrun), 0);

        // overrun: strobe while EXEC
        send(8'h90, 2);
        send(8'h3C, 2);
        @(negedge clk);
        byte_in    = 8'h40;
        byte_valid = 1'b1;
        model_byte(8'h40);
        @(negedge clk);
        byte_in    = 8'h55;
        @(negedge clk);
        byte_valid = 1'b0;
        check("overrun_set", int'(overrun), 1);
        drain("overrun_drain");
        check_state();

        // async reset mid-message
        send(8'h90, 2);
        send(8'h3C, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_note", int'(voice_note), 0);
        check("arst_vel", int'(voice_vel), 0);
        check("arst_active", int'(voice_active), 0);
        check("arst_evt_valid", int'(evt_valid), 0);
        check("arst_evt_voice", int'(evt_voice), 0);
        check("arst_overrun", int'(overrun), 0);
        model_reset();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h3C, 2);
        send(8'h40, 2);
        drain("arst_drain");
        check("arst_idle", int'(voice_active), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
